regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the five-stage pipeline. It provides
//  NRD combinational read ports, two synchronous write ports (WB plus a late/long-latency

---
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports with write bypass, two write ports, per-register pending scoreboard.
// Read latency 0 cycles, writes commit at posedge; no backpressure (every port is accepted every cycle).
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_pend,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);

  // Port 1 is applied last so it wins a same-address double write.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr0_ok) regs_d[wa0] = wd0;
    if (wr1_ok) regs_d[wa1] = wd1;
  end

  // Clear before set: a new producer issued in the writeback cycle keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (we0) pend_d[wa0] = 1'b0;
    if (we1) pend_d[wa1] = 1'b0;
    if (iss_v) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            clr;
    logic            set;
    rs_data = '0;
    rs_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      a   = rs_addr[k*AW +: AW];
      d   = regs_q[a];
      if (wr0_ok && (wa0 == a)) d = wd0;
      if (wr1_ok && (wa1 == a)) d = wd1;
      clr = (we0 && (wa0 == a)) || (we1 && (wa1 == a));
      set = iss_v && (iss_rd == a);
      if (!rst && (a != '0)) begin
        rs_data[k*XLEN +: XLEN] = d;
        rs_pend[k]              = pend_q[a] && !(clr && !set);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp at XLEN=64, NRD=4: hand-computed vector table, reset/x0 sequences, then random traffic against a reference model.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_pend;
  logic                we0, we1, iss_v;
  logic [AW-1:0]       wa0, wa1, iss_rd;
  logic [XLEN-1:0]     wd0, wd1;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_pend(rs_pend),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_v(iss_v), .iss_rd(iss_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        e0; logic [4:0] a0; logic [63:0] d0;
    logic        e1; logic [4:0] a1; logic [63:0] d1;
    logic        iv; logic [4:0] ir;
    logic [19:0] ra; logic [255:0] ed; logic [3:0] ep;
  } vec_t;

  typedef struct {
    string        nm;
    logic [255:0] d;
    logic [3:0]   p;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [63:0] m_regs [NREGS];
  logic [NREGS-1:0] m_pend;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic add(input logic e0, input logic [4:0] a0, input logic [63:0] d0,
                     input logic e1, input logic [4:0] a1, input logic [63:0] d1,
                     input logic iv, input logic [4:0] ir,
                     input logic [19:0] ra, input logic [255:0] ed, input logic [3:0] ep);
    vec_t v;
    v.e0 = e0; v.a0 = a0; v.d0 = d0; v.e1 = e1; v.a1 = a1; v.d1 = d1;
    v.iv = iv; v.ir = ir; v.ra = ra; v.ed = ed; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic e0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic iv, input logic [4:0] ir, input logic [19:0] ra);
    we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    iss_v = iv; iss_rd = ir; rs_addr = ra;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  // Reference model: expected read outputs for the inputs currently driven.
  task automatic model_read(output logic [255:0] ed, output logic [3:0] ep);
    logic [4:0]  a;
    logic [63:0] d;
    logic        c, s;
    ed = '0;
    ep = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rs_addr[k*5 +: 5];
      if (a != 0 && !rst) begin
        d = m_regs[a];
        if (we0 && wa0 == a) d = wd0;
        if (we1 && wa1 == a) d = wd1;
        c = (we0 && wa0 == a) || (we1 && wa1 == a);
        s = iss_v && iss_rd == a;
        ed[k*64 +: 64] = d;
        ep[k] = m_pend[a] && !(c && !s);
      end
    end
  endtask

  task automatic model_commit();
    if (we0 && wa0 != 0) m_regs[wa0] = wd0;
    if (we1 && wa1 != 0) m_regs[wa1] = wd1;
    if (we0) m_pend[wa0] = 1'b0;
    if (we1) m_pend[wa1] = 1'b0;
    if (iss_v && iss_rd != 0) m_pend[iss_rd] = 1'b1;
  endtask

  // One cycle: expectation queued at drive time, checked mid-cycle, state advanced at posedge.
  task automatic cyc(input string nm, input logic [255:0] ed, input logic [3:0] ep);
    exp_t e;
    e.nm = nm; e.d = ed; e.p = ep;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.nm, "_data"}, rs_data, e.d);
    chk({e.nm, "_pend"}, {252'd0, rs_pend}, {252'd0, e.p});
    @(posedge clk);
    if (!rst) model_commit();
    #1;
  endtask

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HI = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] LO = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [255:0] ed;
    logic [3:0]   ep;

    // Vector table, ports listed 3..0 in each concatenation.
    add(0,0,Z, 0,0,Z, 0,0,  {5'd1,5'd2,5'd3,5'd4},   {Z,Z,Z,Z}, 4'b0000);
    add(1,0,FF,0,0,Z, 1,0,  {5'd0,5'd0,5'd0,5'd0},   {Z,Z,Z,Z}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd0,5'd0,5'd0,5'd0},   {Z,Z,Z,Z}, 4'b0000);
    add(1,7,64'h1234,0,0,Z, 0,0, {5'd3,5'd7,5'd0,5'd7}, {Z,64'h1234,Z,64'h1234}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd7,5'd7,5'd7,5'd7},   {4{64'h1234}}, 4'b0000);
    add(1,3,64'hA,1,3,64'hB, 0,0, {5'd7,5'd0,5'd3,5'd3}, {64'h1234,Z,64'hB,64'hB}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd3,5'd3,5'd7,5'd3},   {64'hB,64'hB,64'h1234,64'hB}, 4'b0000);
    add(0,0,Z, 0,0,Z, 1,9,  {5'd9,5'd9,5'd9,5'd9},   {Z,Z,Z,Z}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd9,5'd3,5'd9,5'd9},   {Z,64'hB,Z,Z}, 4'b1011);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd9,5'd3,5'd9,5'd9},   {Z,64'hB,Z,Z}, 4'b1011);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd9,5'd3,5'd9,5'd9},   {Z,64'hB,Z,Z}, 4'b1011);
    add(0,0,Z, 1,9,64'h99, 0,0, {5'd9,5'd9,5'd9,5'd9}, {4{64'h99}}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd9,5'd9,5'd9,5'd9},   {4{64'h99}}, 4'b0000);
    add(1,9,64'h55,0,0,Z, 1,9, {5'd9,5'd9,5'd9,5'd9}, {4{64'h55}}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd9,5'd9,5'd9,5'd9},   {4{64'h55}}, 4'b1111);
    add(1,9,64'h66,0,0,Z, 0,0, {5'd9,5'd9,5'd9,5'd9}, {4{64'h66}}, 4'b0000);
    add(0,0,Z, 0,0,Z, 1,10, {5'd10,5'd10,5'd10,5'd10}, {Z,Z,Z,Z}, 4'b0000);
    add(0,0,Z, 1,10,64'h77, 1,10, {5'd10,5'd9,5'd10,5'd10}, {64'h77,64'h66,64'h77,64'h77}, 4'b1011);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd10,5'd9,5'd10,5'd10}, {64'h77,64'h66,64'h77,64'h77}, 4'b1011);
    add(1,30,LO,1,31,HI, 0,0, {5'd31,5'd30,5'd31,5'd30}, {HI,LO,HI,LO}, 4'b0000);
    add(0,0,Z, 0,0,Z, 0,0,  {5'd31,5'd30,5'd31,5'd30}, {HI,LO,HI,LO}, 4'b0000);

    // Reset held: outputs gated to zero even with a bypassing write present.
    rst = 1'b1;
    drive(1,1,64'h5, 0,0,Z, 1,1, {5'd1,5'd1,5'd1,5'd1});
    model_clear();
    #3;
    @(negedge clk);
    chk("rst_gate_data", rs_data, '0);
    chk("rst_gate_pend", {252'd0, rs_pend}, '0);
    @(posedge clk);
    #1;
    drive(0,0,Z, 0,0,Z, 0,0, '0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].e0, tbl[i].a0, tbl[i].d0, tbl[i].e1, tbl[i].a1, tbl[i].d1,
            tbl[i].iv, tbl[i].ir, tbl[i].ra);
      cyc($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep);
    end

    // Asynchronous reset mid-cycle with a write and an issue in flight.
    drive(1,5,64'hDEAD_BEEF, 0,0,Z, 1,6, {5'd6,5'd5,5'd6,5'd5});
    cyc("rst_pre_wr", {Z,64'hDEAD_BEEF,Z,64'hDEAD_BEEF}, 4'b0000);
    drive(0,0,Z, 0,0,Z, 0,0, {5'd6,5'd5,5'd6,5'd5});
    cyc("rst_pre_rd", {Z,64'hDEAD_BEEF,Z,64'hDEAD_BEEF}, 4'b1010);
    drive(1,5,64'h1, 0,0,Z, 1,7, {5'd6,5'd5,5'd6,5'd5});
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_async_data", rs_data, '0);
    chk("rst_async_pend", {252'd0, rs_pend}, '0);
    @(posedge clk);
    #1;
    drive(0,0,Z, 0,0,Z, 0,0, {5'd7,5'd5,5'd6,5'd5});
    rst = 1'b0;
    cyc("rst_post", {Z,Z,Z,Z}, 4'b0000);

    // Random traffic against the model, addresses biased low to force collisions.
    for (int n = 0; n < 10000; n++) begin
      logic [4:0] ra [4];
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            {ra[3], ra[2], ra[1], ra[0]});
      model_read(ed, ep);
      cyc("rand", ed, ep);
      if (bad > 20) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
